// File: rtl/account_store_arbiter_pkg.sv
// Shared definitions for the account store arbiter: op codes, FSM states and
// the default balance width.
package account_store_arbiter_pkg;

  localparam int DEFAULT_BALANCE_WIDTH = 20;

  localparam logic [1:0] OP_WITHDRAW = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_INQUIRY  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/account_store_arbiter_rr_arbiter.sv
// Round-robin requester pick starting at a registered pointer; the pointer
// moves to one past the last served requester when advance is pulsed.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[(int'(ptr_reg) + k) % NUM_REQ]) begin
        any = 1'b1;
        grant[(int'(ptr_reg) + k) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/account_store_arbiter.sv
// Serialises NUM_REQ requesters onto one balance store; each grant is one
// atomic read-modify-write. Optional macro TXN_COUNT_EN adds txn_count.
module account_store_arbiter
  import account_store_arbiter_pkg::*;
#(
  parameter int balance_width = DEFAULT_BALANCE_WIDTH,
  parameter int NUM_REQ       = 2,
  parameter int ACCT_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [2*NUM_REQ-1:0]            req_op,
  input  logic [ACCT_WIDTH*NUM_REQ-1:0]   req_acct,
  input  logic [balance_width*NUM_REQ-1:0] req_value,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            error,
  output logic [balance_width-1:0]        rdata,
  output logic                            busy
`ifdef TXN_COUNT_EN
  , output logic [15:0]                   txn_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 2 ** ACCT_WIDTH;

  state_t state_reg, state_next;

  logic [1:0]               op_lane    [NUM_REQ];
  logic [ACCT_WIDTH-1:0]    acct_lane  [NUM_REQ];
  logic [balance_width-1:0] value_lane [NUM_REQ];

  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_any;

  logic [1:0]               op_reg;
  logic [ACCT_WIDTH-1:0]    acct_reg;
  logic [balance_width-1:0] value_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [NUM_REQ-1:0]       grant_reg;
  logic [balance_width-1:0] bal_reg;
  logic [balance_width-1:0] result_reg;
  logic                     err_reg;

  logic [balance_width-1:0] store [DEPTH];

  logic [balance_width:0]   exec_sum;
  logic [balance_width-1:0] exec_new;
  logic                     exec_err;
  logic                     capture;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign op_lane[gi]    = req_op[gi*2 +: 2];
      assign acct_lane[gi]  = req_acct[gi*ACCT_WIDTH +: ACCT_WIDTH];
      assign value_lane[gi] = req_value[gi*balance_width +: balance_width];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (state_reg == RESP),
    .last_idx (idx_reg),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  assign capture = (state_reg == IDLE) && arb_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = grant_reg;
    done       = '0;
    error      = 1'b0;
    rdata      = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (arb_any) state_next = READ;
      READ: state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: begin
        state_next = IDLE;
        done       = grant_reg;
        error      = err_reg;
        rdata      = result_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  // Deposit overflow is detected in the extra carry bit of the sum.
  always_comb begin
    exec_sum = {1'b0, bal_reg} + {1'b0, value_reg};
    exec_new = bal_reg;
    exec_err = 1'b0;
    case (op_reg)
      OP_WITHDRAW: begin
        if (value_reg > bal_reg) exec_err = 1'b1;
        else                     exec_new = bal_reg - value_reg;
      end
      OP_DEPOSIT: begin
        if (exec_sum[balance_width]) exec_err = 1'b1;
        else                         exec_new = exec_sum[balance_width-1:0];
      end
      OP_INQUIRY: exec_new = bal_reg;
      default:    exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg     <= '0;
      acct_reg   <= '0;
      value_reg  <= '0;
      idx_reg    <= '0;
      grant_reg  <= '0;
      bal_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (capture) begin
        op_reg    <= op_lane[arb_idx];
        acct_reg  <= acct_lane[arb_idx];
        value_reg <= value_lane[arb_idx];
        idx_reg   <= arb_idx;
        grant_reg <= arb_grant;
      end
      if (state_reg == READ) begin
        bal_reg <= store[acct_reg];
      end
      if (state_reg == EXEC) begin
        err_reg    <= exec_err;
        result_reg <= exec_err ? bal_reg : exec_new;
      end
      if (state_reg == RESP) begin
        grant_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (state_reg == EXEC && !exec_err) begin
      store[acct_reg] <= exec_new;
    end
  end

`ifdef TXN_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_count <= '0;
    end else if (state_reg == RESP && !err_reg && txn_count != 16'hFFFF) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/account_store_arbiter.md
Name: account_store_arbiter

Overview:
- Owns the account balance store and serialises access to it from NUM_REQ requesters (ATM front-end FSMs, back-office port).
- Each granted request is one atomic read-modify-write: withdraw, deposit or inquiry on one account, then a one-cycle completion pulse with the resulting balance.
- Sits between the ATM session FSMs and the balance storage. It replaces per-FSM balance arithmetic with a single checked datapath.

Parameters:
- balance_width, 20, width of every balance and value.
- NUM_REQ, 2, number of requesters (2..8).
- ACCT_WIDTH, 4, account index width; store depth = 2**ACCT_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_op  input  2*NUM_REQ  per-requester op: withdraw 2'b00, deposit 2'b01, inquiry 2'b10, 2'b11 illegal.
- req_acct  input  ACCT_WIDTH*NUM_REQ  per-requester account index.
- req_value  input  balance_width*NUM_REQ  per-requester amount; ignored for inquiry.
- grant  output  NUM_REQ  one-hot; high from capture until completion for the owning requester.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- error  output  1  valid with done; 1 = transaction rejected.
- rdata  output  balance_width  valid with done; account balance after the transaction (unchanged if error).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; state = IDLE.
  - Round-robin pointer = 0.
  - Every account balance = 0.
- States, one cycle each:
  - IDLE: if any req, choose requester by round-robin from pointer. Capture op/acct/value, set grant, go READ. Otherwise stay.
  - READ: bal_q <= store[acct]. Go EXEC.
  - EXEC:
    - withdraw: error if value > bal_q; else new = bal_q - value.
    - deposit: error if bal_q + value overflows balance_width (compute with 1 extra bit); else new = sum.
    - inquiry: new = bal_q, never error.
    - op 2'b11: error.
    - On no error, write new to store[acct]; on error, no write. Go RESP.
  - RESP: done[idx]=1, error and rdata valid, grant still high. Next cycle: grant drops, pointer <= idx+1 mod NUM_REQ, go IDLE.
- Latency: req sampled in IDLE at cycle T; done at T+3; next grant earliest at T+4. A requester never waits more than NUM_REQ transactions.
- Requester rules:
  - Holds req, op, acct and value stable until done; values are captured in IDLE, so later changes are ignored.
  - A request is consumed at done. req still high in the following IDLE cycle is a new request.
  - Deasserting req while granted does not abort the transaction.
- Simultaneous requests: only one grant. Losers keep req high and are served in round-robin order.
- Same account from two requesters: strictly serialised; the second sees the first's committed balance.
- Reset mid-transaction: the in-flight write is discarded if reset arrives before the EXEC edge. Store clears to 0 regardless.
- done, error and rdata are 0 outside RESP.

Optional Feature:
- Macro TXN_COUNT_EN.
- With the macro defined, add output txn_count [15:0]:
  - Increments in RESP for every non-error transaction; saturates at 16'hFFFF.
  - Cleared by reset.
- Without the macro: no port and no counter logic.

Decomposition:
- Shared package:
  - Op-code constants (OP_WITHDRAW, OP_DEPOSIT, OP_INQUIRY).
  - State encoding (IDLE, READ, EXEC, RESP).
  - Default balance_width.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin pick with pointer input; outputs one-hot grant and binary index. Purely combinational plus pointer register.

Test Plan:
- Reset, then req0 deposit 500 to acct 3 → done[0] at T+3, error=0, rdata=500. Inquiry acct 3 → rdata=500.
- acct 3 = 500; req1 withdraw 600 → error=1, rdata=500. Inquiry → 500 (no write).
- acct 5 = 20'hFFF00; deposit 20'h200 → error=1, rdata=20'hFFF00. Deposit 20'hFF → rdata=20'hFFFFF, error=0.
- req0 and req1 both withdraw 100 from acct 3 (500) in the same cycle, pointer=0:
  - req0 completes first with rdata=400; req1 next with rdata=300.
  - Pointer then favours req0 again when both request.
- op 2'b11 → error=1, no store change. Reset asserted during EXEC → all outputs 0, all balances 0.
- With TXN_COUNT_EN: 3 successful and 1 failed transaction → txn_count=3.
